mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory stage of the Y86-64 processor; sits between execute and write-back and directly drives the byte-addressed 64-bit data memory (DataMem).
- Decodes icode into read/write enables, selects address and write data, and range-checks the address.
- Absorbs the memory's one-cycle registered read latency and produces one write-back record per instruction.

Parameters:
N, 64, data/address width
MEM_BYTES, 65536, data memory size in bytes; legal address range 0..MEM_BYTES-8

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
in_valid  in  1  execute-stage record valid
in_ready  out  1  stage accepts a record this cycle
in_stat  in  3  status: AOK=1, ADR=2, INS=3, HLT=4
in_icode  in  4  instruction code
in_valE  in  N  ALU result
in_valA  in  N  register operand A
in_valP  in  N  next PC
in_dstE  in  4  E destination register (RNONE=0xF)
in_dstM  in  4  M destination register
mem_addr  out  N  to DataMem inAdd
mem_wdata  out  N  to DataMem inData
mem_rEn  out  1  DataMem read enable
mem_wEn  out  1  DataMem write enable
mem_err  out  1  DataMem dmem_err
mem_rdata  in  N  DataMem outData, valid the cycle after the read edge
out_valid  out  1  write-back record valid (one-cycle pulse per instruction)
out_stat  out  3  final status
out_icode  out  4
out_valE  out  N
out_valM  out  N  memory read data; 0 for non-reads
out_dstE  out  4
out_dstM  out  4
halted  out  1  sticky: a non-AOK record has been emitted

Behaviour:
- Accept = in_valid & in_ready. Memory ports are combinational from in_* and are active only on accept; otherwise rEn=wEn=err=0, addr=wdata=0.
- Read ops: MRMOVQ(5), POPQ(B), RET(9). Write ops: RMMOVQ(4), PUSHQ(A), CALL(8).
- Address: valA for POPQ/RET; valE for all other memory ops. Write data: valP for CALL; valA for RMMOVQ/PUSHQ.
- Range error: memory op with addr > MEM_BYTES-8 (unsigned, all N bits) -> mem_err=1, rEn=wEn=0, out_stat=ADR.
- in_stat != AOK: no memory access (rEn=wEn=err=0); stat passes through unchanged.
- FSM states:
  - IDLE: in_ready = ~halted.
    - Non-read, error, or faulted accepted record -> output registers loaded at this edge; out_valid=1 next cycle (latency 1).
    - Legal read accepted -> fields latched into a hold register; go to RD_WAIT.
  - RD_WAIT: in_ready=0; mem ports quiet. At the next edge, out_* <= held fields, out_valM <= mem_rdata, out_valid=1 next cycle (latency 2); return to IDLE.
- A write completes at the accept edge; back-to-back non-read ops sustain 1 record/cycle. A read costs one bubble.
- halted: set when a record with out_stat != AOK is loaded into the output registers. While set, in_ready=0, mem ports stay quiet, and out_valid=0 after the final record.
- Reset (any state, including RD_WAIT): state=IDLE, halted=0, hold register discarded, out_valid=0, out_stat=AOK, out_icode=1 (NOP), out_valE=out_valM=0, out_dstE=out_dstM=0xF. mem_rEn=mem_wEn=mem_err=0 during the reset cycle regardless of in_*.
- out_valM=0 for all non-read records, including error records.

Decomposition:
- Package y86_pkg holds:
  - icode constants HALT..POPQ
  - stat codes AOK/ADR/INS/HLT
  - RNONE
  - FSM state enum {IDLE, RD_WAIT}
- Sub-module mem_access_decode (combinational): icode/stat/valE/valA/valP -> rd, wr, addr, wdata, range_err.
- FSM, hold register, and output registers stay in mem_stage_ctrl.

Test Plan:
- RMMOVQ valE=0x100, valA=0x1122334455667788 -> wEn=1 at addr 0x100 for one cycle; out_valid next cycle, out_valM=0, stat AOK.
- Then MRMOVQ valE=0x100, dstM=3 -> in_ready=0 for one cycle; out_valid 2 cycles after accept with out_valM=0x1122334455667788, out_dstM=3.
- CALL valE=0x1F8, valP=0x40, then RET valA=0x1F8 -> memory holds 0x40 at 0x1F8; RET record shows out_valM=0x40.
- MRMOVQ valE=0xFFF9 -> mem_err=1, rEn=0; out_stat=ADR, halted=1; a following valid OPQ sees in_ready=0 and no out_valid.
- HALT with in_stat=HLT -> no memory access, out_stat=HLT, halted=1. Then assert reset -> halted=0, in_ready=1, out_valid=0.
- Assert reset during RD_WAIT of a POPQ -> no out_valid for the POPQ; FSM back in IDLE; next RMMOVQ accepted the cycle after reset deasserts.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the memory stage: instruction codes,
// status codes, register sentinel and the memory-stage FSM states.
package y86_pkg;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_ADR = 3'd2,
        STAT_INS = 3'd3,
        STAT_HLT = 3'd4
    } stat_e;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    function automatic logic is_read_op(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ) || (icode == I_RET);
    endfunction

    function automatic logic is_write_op(input logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
    endfunction

endpackage

// File: rtl/mem_access_decode.sv
// Combinational memory-access decode: picks address and write data from the
// execute record, qualifies read/write by status and flags out-of-range addresses.
module mem_access_decode
    import y86_pkg::*;
#(
    parameter int N         = 64,
    parameter int MEM_BYTES = 65536
) (
    input  logic [3:0]   icode,
    input  logic [2:0]   stat,
    input  logic [N-1:0] valE,
    input  logic [N-1:0] valA,
    input  logic [N-1:0] valP,
    output logic         rd,
    output logic         wr,
    output logic [N-1:0] addr,
    output logic [N-1:0] wdata,
    output logic         range_err
);

    // Highest address at which a full 8-byte word still fits in memory.
    localparam logic [N-1:0] LAST_ADDR = N'(MEM_BYTES - 8);

    logic is_rd;
    logic is_wr;
    logic stat_ok;

    always_comb begin
        is_rd   = is_read_op(icode);
        is_wr   = is_write_op(icode);
        stat_ok = (stat == STAT_AOK);

        // Stack pops read through the old stack pointer carried in valA.
        addr  = ((icode == I_POPQ) || (icode == I_RET)) ? valA : valE;
        wdata = (icode == I_CALL) ? valP : valA;

        range_err = stat_ok && (is_rd || is_wr) && (addr > LAST_ADDR);
        rd        = stat_ok && is_rd && !range_err;
        wr        = stat_ok && is_wr && !range_err;
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Y86-64 memory stage: drives DataMem, hides its one-cycle read latency and
// emits exactly one write-back record per accepted instruction.
module mem_stage_ctrl
    import y86_pkg::*;
#(
    parameter int N         = 64,
    parameter int MEM_BYTES = 65536
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_stat,
    input  logic [3:0]   in_icode,
    input  logic [N-1:0] in_valE,
    input  logic [N-1:0] in_valA,
    input  logic [N-1:0] in_valP,
    input  logic [3:0]   in_dstE,
    input  logic [3:0]   in_dstM,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic         mem_rEn,
    output logic         mem_wEn,
    output logic         mem_err,
    input  logic [N-1:0] mem_rdata,
    output logic         out_valid,
    output logic [2:0]   out_stat,
    output logic [3:0]   out_icode,
    output logic [N-1:0] out_valE,
    output logic [N-1:0] out_valM,
    output logic [3:0]   out_dstE,
    output logic [3:0]   out_dstM,
    output logic         halted
);

    state_e       state;
    state_e       state_next;

    logic         accept;
    logic         dec_rd;
    logic         dec_wr;
    logic         dec_err;
    logic [N-1:0] dec_addr;
    logic [N-1:0] dec_wdata;
    logic [2:0]   direct_stat;

    logic         load_direct;
    logic         load_hold;
    logic         load_read;

    logic [3:0]   hold_icode;
    logic [N-1:0] hold_valE;
    logic [3:0]   hold_dstE;
    logic [3:0]   hold_dstM;

    mem_access_decode #(
        .N         (N),
        .MEM_BYTES (MEM_BYTES)
    ) u_decode (
        .icode     (in_icode),
        .stat      (in_stat),
        .valE      (in_valE),
        .valA      (in_valA),
        .valP      (in_valP),
        .rd        (dec_rd),
        .wr        (dec_wr),
        .addr      (dec_addr),
        .wdata     (dec_wdata),
        .range_err (dec_err)
    );

    // Nothing is taken while reset is high, so the memory stays untouched then.
    assign in_ready = !reset && (state == IDLE) && !halted;
    assign accept   = in_valid && in_ready;

    assign mem_rEn   = accept && dec_rd;
    assign mem_wEn   = accept && dec_wr;
    assign mem_err   = accept && dec_err;
    assign mem_addr  = accept ? dec_addr  : '0;
    assign mem_wdata = accept ? dec_wdata : '0;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        state_next  = state;
        load_direct = 1'b0;
        load_hold   = 1'b0;
        load_read   = 1'b0;
        direct_stat = STAT_AOK;

        if (in_stat != STAT_AOK) begin
            direct_stat = in_stat;
        end else if (dec_err) begin
            direct_stat = STAT_ADR;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    if (dec_rd) begin
                        load_hold  = 1'b1;
                        state_next = RD_WAIT;
                    end else begin
                        load_direct = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                load_read  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the hold register is pure datapath and is not reset; RD_WAIT is the only reader and reset leaves it.
    always_ff @(posedge clk) begin
        if (load_hold) begin
            hold_icode <= in_icode;
            hold_valE  <= in_valE;
            hold_dstE  <= in_dstE;
            hold_dstM  <= in_dstM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_stat  <= STAT_AOK;
            out_icode <= I_NOP;
            out_valE  <= '0;
            out_valM  <= '0;
            out_dstE  <= RNONE;
            out_dstM  <= RNONE;
            halted    <= 1'b0;
        end else begin
            out_valid <= load_direct || load_read;
            if (load_direct) begin
                out_stat  <= direct_stat;
                out_icode <= in_icode;
                out_valE  <= in_valE;
                out_valM  <= '0;
                out_dstE  <= in_dstE;
                out_dstM  <= in_dstM;
                if (direct_stat != STAT_AOK) begin
                    halted <= 1'b1;
                end
            end else if (load_read) begin
                // A read only reaches RD_WAIT when legal, so its status is always AOK.
                out_stat  <= STAT_AOK;
                out_icode <= hold_icode;
                out_valE  <= hold_valE;
                out_valM  <= mem_rdata;
                out_dstE  <= hold_dstE;
                out_dstM  <= hold_dstM;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl with a registered-read data memory model.
module tb_mem_stage_ctrl;
    import y86_pkg::*;

    localparam logic [63:0] D0 = 64'h1122334455667788;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_stat = 3'd1;
    logic [3:0]  in_icode = 4'h1;
    logic [63:0] in_valE = '0;
    logic [63:0] in_valA = '0;
    logic [63:0] in_valP = '0;
    logic [3:0]  in_dstE = 4'hF;
    logic [3:0]  in_dstM = 4'hF;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_rEn;
    logic        mem_wEn;
    logic        mem_err;
    logic [63:0] mem_rdata = '0;
    logic        out_valid;
    logic [2:0]  out_stat;
    logic [3:0]  out_icode;
    logic [63:0] out_valE;
    logic [63:0] out_valM;
    logic [3:0]  out_dstE;
    logic [3:0]  out_dstM;
    logic        halted;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_tries = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [63:0] dmem [logic [63:0]];

    mem_stage_ctrl #(.N(64), .MEM_BYTES(65536)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_stat   (in_stat),
        .in_icode  (in_icode),
        .in_valE   (in_valE),
        .in_valA   (in_valA),
        .in_valP   (in_valP),
        .in_dstE   (in_dstE),
        .in_dstM   (in_dstM),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rEn   (mem_rEn),
        .mem_wEn   (mem_wEn),
        .mem_err   (mem_err),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_stat  (out_stat),
        .out_icode (out_icode),
        .out_valE  (out_valE),
        .out_valM  (out_valM),
        .out_dstE  (out_dstE),
        .out_dstM  (out_dstM),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DataMem model: write at the edge, read data registered for the next cycle.
    always @(posedge clk) begin
        if (mem_wEn) dmem[mem_addr] = mem_wdata;
        if (mem_rEn) mem_rdata <= dmem.exists(mem_addr) ? dmem[mem_addr] : 64'h0;
    end

    // Write-back monitor: every out_valid pulse must match the oldest expected record.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_out_valid: icode=%h stat=%0d at cycle %0d, required no record", out_icode, out_stat, cyc);
                n_fail++;
            end else begin
                mon_e = sb.pop_front();
                if ({out_stat, out_icode, out_valE, out_valM, out_dstE, out_dstM} !==
                    {mon_e.stat, mon_e.icode, mon_e.valE, mon_e.valM, mon_e.dstE, mon_e.dstM}) begin
                    $display("FAIL wb_record: got stat=%0d icode=%h valE=%h valM=%h dstE=%h dstM=%h, required stat=%0d icode=%h valE=%h valM=%h dstE=%h dstM=%h",
                             out_stat, out_icode, out_valE, out_valM, out_dstE, out_dstM,
                             mon_e.stat, mon_e.icode, mon_e.valE, mon_e.valM, mon_e.dstE, mon_e.dstM);
                    n_fail++;
                end
                n_checks++;
                if (cyc != mon_e.cyc) begin
                    $display("FAIL wb_latency: icode=%h emitted at cycle %0d, required %0d", out_icode, cyc, mon_e.cyc);
                    n_fail++;
                end
            end
        end
    end

    task automatic set_in(input logic v, input logic [2:0] st, input logic [3:0] ic,
                          input logic [63:0] ve, input logic [63:0] va, input logic [63:0] vp,
                          input logic [3:0] de, input logic [3:0] dm);
        in_valid = v;
        in_stat  = st;
        in_icode = ic;
        in_valE  = ve;
        in_valA  = va;
        in_valP  = vp;
        in_dstE  = de;
        in_dstM  = dm;
    endtask

    // Offers a record each negedge until accepted; returns at negedge+1 with inputs still applied.
    task automatic send(input logic [2:0] st, input logic [3:0] ic,
                        input logic [63:0] ve, input logic [63:0] va, input logic [63:0] vp,
                        input logic [3:0] de, input logic [3:0] dm,
                        input bit expect_out, input logic [2:0] exp_st,
                        input logic [63:0] exp_m, input int lat);
        exp_t e;
        int   tries = 0;
        forever begin
            @(negedge clk);
            set_in(1'b1, st, ic, ve, va, vp, de, dm);
            #1;
            if (in_ready === 1'b1) break;
            tries++;
            if (tries > 8) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: icode=%h never accepted, in_ready=%b required 1", ic, in_ready);
                in_valid = 1'b0;
                last_tries = tries;
                return;
            end
        end
        last_tries = tries;
        if (expect_out) begin
            e.stat  = exp_st;
            e.icode = ic;
            e.valE  = ve;
            e.valM  = exp_m;
            e.dstE  = de;
            e.dstM  = dm;
            e.cyc   = cyc + lat;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && i < 8) begin
            @(negedge clk);
            #2;
            i++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d records outstanding, required 0", sb.size());
            n_fail++;
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        set_in(1'b1, STAT_AOK, I_RMMOVQ, 64'h100, 64'h55, 64'h0, RNONE, RNONE);
        #1;
        n_checks++;
        if ({mem_rEn, mem_wEn, mem_err} !== 3'b000) begin
            $display("FAIL reset_mem_quiet: rEn,wEn,err=%b required 000", {mem_rEn, mem_wEn, mem_err});
            n_fail++;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_stat, out_icode, out_valE, out_valM, out_dstE, out_dstM, halted} !==
            {1'b0, 3'd1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0}) begin
            $display("FAIL reset_outputs: valid=%b stat=%0d icode=%h valE=%h valM=%h dstE=%h dstM=%h halted=%b required 0 1 1 0 0 f f 0",
                     out_valid, out_stat, out_icode, out_valE, out_valM, out_dstE, out_dstM, halted);
            n_fail++;
        end
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
            n_fail++;
        end
    endtask

    task automatic test_write_read();
        send(STAT_AOK, I_RMMOVQ, 64'h100, D0, 64'h0, RNONE, RNONE, 1, STAT_AOK, 64'h0, 1);
        n_checks++;
        if ({mem_wEn, mem_rEn, mem_err, mem_addr, mem_wdata} !== {3'b100, 64'h100, D0}) begin
            $display("FAIL rmmovq_port: wEn,rEn,err=%b addr=%h wdata=%h required 100 addr=100 wdata=%h",
                     {mem_wEn, mem_rEn, mem_err}, mem_addr, mem_wdata, D0);
            n_fail++;
        end
        send(STAT_AOK, I_MRMOVQ, 64'h100, 64'h5555, 64'h0, RNONE, 4'd3, 1, STAT_AOK, D0, 2);
        n_checks++;
        if ({last_tries == 0, mem_rEn, mem_wEn, mem_err, mem_addr} !== {4'b1100, 64'h100}) begin
            $display("FAIL mrmovq_port: tries=%0d rEn,wEn,err=%b addr=%h required tries=0 100 addr=100",
                     last_tries, {mem_rEn, mem_wEn, mem_err}, mem_addr);
            n_fail++;
        end
        @(negedge clk);
        set_in(1'b1, STAT_AOK, I_OPQ, 64'h9, 64'h0, 64'h0, 4'd1, RNONE);
        #1;
        n_checks++;
        if ({in_ready, mem_rEn, mem_wEn, mem_err} !== 4'b0000) begin
            $display("FAIL rd_wait_bubble: in_ready,rEn,wEn,err=%b required 0000", {in_ready, mem_rEn, mem_wEn, mem_err});
            n_fail++;
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_call_ret();
        send(STAT_AOK, I_CALL, 64'h1F8, 64'h999, 64'h40, 4'd4, RNONE, 1, STAT_AOK, 64'h0, 1);
        n_checks++;
        if ({mem_wEn, mem_rEn, mem_addr, mem_wdata} !== {2'b10, 64'h1F8, 64'h40}) begin
            $display("FAIL call_port: wEn,rEn=%b addr=%h wdata=%h required 10 addr=1f8 wdata=40",
                     {mem_wEn, mem_rEn}, mem_addr, mem_wdata);
            n_fail++;
        end
        send(STAT_AOK, I_RET, 64'h200, 64'h1F8, 64'h0, 4'd4, RNONE, 1, STAT_AOK, 64'h40, 2);
        n_checks++;
        if ({mem_rEn, mem_wEn, mem_addr} !== {2'b10, 64'h1F8}) begin
            $display("FAIL ret_port: rEn,wEn=%b addr=%h required 10 addr=1f8", {mem_rEn, mem_wEn}, mem_addr);
            n_fail++;
        end
        idle();
        drain();
        n_checks++;
        if (!dmem.exists(64'h1F8) || dmem[64'h1F8] !== 64'h40) begin
            $display("FAIL call_mem: word at 1f8 not written with 40");
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        send(STAT_AOK, I_IRMOVQ, 64'h7, 64'h0, 64'h0, 4'd2, RNONE, 1, STAT_AOK, 64'h0, 1);
        send(STAT_AOK, I_OPQ, 64'h1234, 64'h3, 64'h0, 4'd5, RNONE, 1, STAT_AOK, 64'h0, 1);
        n_checks++;
        if (last_tries != 0) begin
            $display("FAIL b2b_opq: accepted after %0d stalls, required 0", last_tries);
            n_fail++;
        end
        send(STAT_AOK, I_PUSHQ, 64'hFFF8, 64'hCAFE, 64'h0, 4'd4, RNONE, 1, STAT_AOK, 64'h0, 1);
        n_checks++;
        if ({last_tries == 0, mem_wEn, mem_err, mem_addr, mem_wdata} !== {3'b110, 64'hFFF8, 64'hCAFE}) begin
            $display("FAIL b2b_pushq: tries=%0d wEn,err=%b addr=%h wdata=%h required tries=0 10 addr=fff8 wdata=cafe",
                     last_tries, {mem_wEn, mem_err}, mem_addr, mem_wdata);
            n_fail++;
        end
        send(STAT_AOK, I_NOP, 64'h0, 64'h0, 64'h0, RNONE, RNONE, 1, STAT_AOK, 64'h0, 1);
        n_checks++;
        if (last_tries != 0) begin
            $display("FAIL b2b_nop: accepted after %0d stalls, required 0", last_tries);
            n_fail++;
        end
        // Last legal word, addressed through valA; valE is deliberately out of range.
        send(STAT_AOK, I_POPQ, 64'h10000, 64'hFFF8, 64'h0, 4'd4, 4'd6, 1, STAT_AOK, 64'hCAFE, 2);
        n_checks++;
        if ({mem_rEn, mem_err, mem_addr} !== {2'b10, 64'hFFF8}) begin
            $display("FAIL popq_boundary: rEn,err=%b addr=%h required 10 addr=fff8", {mem_rEn, mem_err}, mem_addr);
            n_fail++;
        end
        idle();
        drain();
    endtask

    task automatic test_reset_rd_wait();
        send(STAT_AOK, I_POPQ, 64'h10008, 64'hFFF8, 64'h0, 4'd4, 4'd7, 0, STAT_AOK, 64'h0, 2);
        @(negedge clk);
        reset = 1'b1;
        set_in(1'b1, STAT_AOK, I_RMMOVQ, 64'h200, 64'h77, 64'h0, RNONE, RNONE);
        #1;
        n_checks++;
        if ({mem_rEn, mem_wEn, mem_err} !== 3'b000) begin
            $display("FAIL rd_wait_reset_ports: rEn,wEn,err=%b required 000", {mem_rEn, mem_wEn, mem_err});
            n_fail++;
        end
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            $display("FAIL rd_wait_reset_state: in_ready,out_valid=%b required 10", {in_ready, out_valid});
            n_fail++;
        end
        send(STAT_AOK, I_RMMOVQ, 64'h208, 64'h88, 64'h0, RNONE, RNONE, 1, STAT_AOK, 64'h0, 1);
        n_checks++;
        if ({last_tries == 0, mem_wEn} !== 2'b11) begin
            $display("FAIL post_reset_accept: tries=%0d wEn=%b required tries=0 wEn=1", last_tries, mem_wEn);
            n_fail++;
        end
        idle();
        drain();
    endtask

    task automatic test_range_error();
        send(STAT_AOK, I_MRMOVQ, 64'hFFF9, 64'h0, 64'h0, RNONE, 4'd3, 1, STAT_ADR, 64'h0, 1);
        n_checks++;
        if ({mem_err, mem_rEn, mem_wEn} !== 3'b100) begin
            $display("FAIL range_err_port: err,rEn,wEn=%b required 100", {mem_err, mem_rEn, mem_wEn});
            n_fail++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (halted !== 1'b1) begin
            $display("FAIL range_halted: halted=%b required 1", halted);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_in(1'b1, STAT_AOK, I_OPQ, 64'h5, 64'h0, 64'h0, 4'd1, RNONE);
            #1;
            n_checks++;
            if ({in_ready, mem_rEn, mem_wEn, mem_err} !== 4'b0000) begin
                $display("FAIL halted_blocks: in_ready,rEn,wEn,err=%b required 0000", {in_ready, mem_rEn, mem_wEn, mem_err});
                n_fail++;
            end
        end
        drain();
        do_reset();
        // Upper address bits must count: a small low word with bit 63 set is still out of range.
        send(STAT_AOK, I_RMMOVQ, 64'h8000_0000_0000_0100, 64'h1, 64'h0, RNONE, RNONE, 1, STAT_ADR, 64'h0, 1);
        n_checks++;
        if ({mem_err, mem_wEn} !== 2'b10) begin
            $display("FAIL range_high_bits: err,wEn=%b required 10", {mem_err, mem_wEn});
            n_fail++;
        end
        idle();
        drain();
        do_reset();
    endtask

    task automatic test_halt();
        send(STAT_HLT, I_HALT, 64'h0, 64'h0, 64'h0, RNONE, RNONE, 1, STAT_HLT, 64'h0, 1);
        n_checks++;
        if ({mem_rEn, mem_wEn, mem_err} !== 3'b000) begin
            $display("FAIL halt_port: rEn,wEn,err=%b required 000", {mem_rEn, mem_wEn, mem_err});
            n_fail++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({halted, in_ready} !== 2'b10) begin
            $display("FAIL halt_sticky: halted,in_ready=%b required 10", {halted, in_ready});
            n_fail++;
        end
        drain();
        do_reset();
        #1;
        n_checks++;
        if ({halted, in_ready, out_valid} !== 3'b010) begin
            $display("FAIL halt_reset: halted,in_ready,out_valid=%b required 010", {halted, in_ready, out_valid});
            n_fail++;
        end
        // A faulted read passes its status through and never touches memory.
        send(STAT_INS, I_MRMOVQ, 64'h100, 64'h0, 64'h0, RNONE, 4'd2, 1, STAT_INS, 64'h0, 1);
        n_checks++;
        if ({mem_rEn, mem_wEn, mem_err} !== 3'b000) begin
            $display("FAIL faulted_read_port: rEn,wEn,err=%b required 000", {mem_rEn, mem_wEn, mem_err});
            n_fail++;
        end
        idle();
        drain();
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_call_ret();
        test_back_to_back();
        test_reset_rd_wait();
        test_range_error();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
